// File: rtl/i2s_dsp_rx_deser.sv
// DSP-mode (frame-sync pulse) serial-to-parallel receiver feeding the I2S RX FIFO.
// Optional feature macro: I2S_DSP_RX_SIGN_EXT_EN (adds cfg_sign_ext_i, MSB replication above word length).
module i2s_dsp_rx_deser #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              sck_i,
  input  logic              rstn_i,
  input  logic              cfg_en_i,
  input  logic [4:0]        cfg_num_bits_i,
  input  logic [IDX_W-1:0]  cfg_num_words_i,
  input  logic              cfg_data_delay_i,
  input  logic              cfg_lsb_first_i,
`ifdef I2S_DSP_RX_SIGN_EXT_EN
  input  logic              cfg_sign_ext_i,
`endif
  input  logic              ws_i,
  input  logic              sd_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [IDX_W-1:0]  word_idx_o,
  output logic              ovf_o,
  output logic              frame_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DELAY, S_SHIFT} state_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_bit_cnt, r_nbits, w_nb, w_bcnt;
  logic [IDX_W-1:0]  r_word_cnt, r_nwords, w_nw, w_wcnt, r_idx;
  logic              r_lsb_first, w_lsb;
  logic [DATA_W-1:0] r_shreg, w_base, w_shifted, w_word, r_data;
  logic              r_valid, r_ovf, r_ferr;
  logic              w_in_frame, w_last_bit, w_legal_ws, w_restart;
  logic              w_sample, w_done, w_frame_end, w_pop;
`ifdef I2S_DSP_RX_SIGN_EXT_EN
  logic [DATA_W-1:0] w_hi_mask;
`endif

  always_comb begin
    w_in_frame = (r_state == S_DELAY) || (r_state == S_SHIFT);
    w_last_bit = w_in_frame && (r_bit_cnt == r_nbits) && (r_word_cnt == r_nwords);
    w_legal_ws = cfg_en_i && ws_i && w_last_bit;
    w_restart  = cfg_en_i && ws_i && !w_last_bit && (w_in_frame || (r_state == S_SYNC));

    w_sample = 1'b0;
    w_nb     = r_nbits;
    w_nw     = r_nwords;
    w_lsb    = r_lsb_first;
    w_bcnt   = r_bit_cnt;
    w_wcnt   = r_word_cnt;
    w_base   = r_shreg;
    // A restart behaves like a fresh frame: new config, empty word, bit 0 now unless delayed
    if (w_restart) begin
      w_nb     = cfg_num_bits_i;
      w_nw     = cfg_num_words_i;
      w_lsb    = cfg_lsb_first_i;
      w_bcnt   = '0;
      w_wcnt   = '0;
      w_base   = '0;
      w_sample = !cfg_data_delay_i;
    end else if (cfg_en_i && w_in_frame) begin
      w_sample = 1'b1;
    end

    if (w_lsb)
      w_shifted = w_base | ({{(DATA_W-1){1'b0}}, sd_i} << w_bcnt);
    else
      w_shifted = {w_base[DATA_W-2:0], sd_i};

    w_word = w_shifted;
`ifdef I2S_DSP_RX_SIGN_EXT_EN
    w_hi_mask = ({DATA_W{1'b1}} << w_nb) << 1;
    if (cfg_sign_ext_i && w_shifted[w_nb])
      w_word = w_shifted | w_hi_mask;
`endif

    w_done      = w_sample && (w_bcnt == w_nb);
    w_frame_end = w_done && (w_wcnt == w_nw);
    w_pop       = r_valid && data_ready_i;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!cfg_en_i)
      w_state_nxt = S_IDLE;
    else if (r_state == S_IDLE)
      w_state_nxt = S_SYNC;
    else if (w_legal_ws)
      w_state_nxt = cfg_data_delay_i ? S_DELAY : S_SHIFT;
    else if (w_frame_end)
      w_state_nxt = S_SYNC;
    else if (w_restart)
      w_state_nxt = cfg_data_delay_i ? S_DELAY : S_SHIFT;
    else if (r_state == S_DELAY)
      w_state_nxt = S_SHIFT;
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_shreg     <= '0;
      r_nbits     <= '0;
      r_nwords    <= '0;
      r_lsb_first <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_idx       <= '0;
      r_ovf       <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      if (!cfg_en_i) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_shreg    <= '0;
        r_ovf      <= 1'b0;
        r_ferr     <= 1'b0;
      end else begin
        if (w_restart || w_legal_ws) begin
          r_nbits     <= cfg_num_bits_i;
          r_nwords    <= cfg_num_words_i;
          r_lsb_first <= cfg_lsb_first_i;
        end
        if (w_restart && (r_state != S_SYNC))
          r_ferr <= 1'b1;
        if (w_legal_ws || (w_restart && cfg_data_delay_i)) begin
          r_bit_cnt  <= '0;
          r_word_cnt <= '0;
          r_shreg    <= '0;
        end else if (w_sample) begin
          if (w_done) begin
            r_bit_cnt  <= '0;
            r_word_cnt <= w_frame_end ? '0 : IDX_W'(w_wcnt + 1'b1);
            r_shreg    <= '0;
          end else begin
            r_bit_cnt  <= 5'(w_bcnt + 5'd1);
            r_word_cnt <= w_wcnt;
            r_shreg    <= w_shifted;
          end
        end
        if (w_done && r_valid && !data_ready_i)
          r_ovf <= 1'b1;
      end

      // Output register: a pop and a new word on the same edge keeps valid high
      if (w_done && (!r_valid || data_ready_i)) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
        r_idx   <= w_wcnt;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign word_idx_o   = r_idx;
  assign ovf_o        = r_ovf;
  assign frame_err_o  = r_ferr;

endmodule

// File: tb/tb_i2s_dsp_rx_deser.sv
// Directed self-checking bench for i2s_dsp_rx_deser (DSP frame-sync receive mode).
`timescale 1ns/1ps
module tb_i2s_dsp_rx_deser;

  logic        sck_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i;
  logic [4:0]  cfg_num_bits_i;
  logic [3:0]  cfg_num_words_i;
  logic        cfg_data_delay_i;
  logic        cfg_lsb_first_i;
`ifdef I2S_DSP_RX_SIGN_EXT_EN
  logic        cfg_sign_ext_i;
`endif
  logic        ws_i;
  logic        sd_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [3:0]  word_idx_o;
  logic        ovf_o;
  logic        frame_err_o;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt  = 0;
  logic [31:0] mon_data[$];
  logic [3:0]  mon_idx[$];
  logic        st_ws[$];
  logic        st_sd[$];

  i2s_dsp_rx_deser #(.DATA_W(32), .IDX_W(4)) dut (
    .sck_i            (sck_i),
    .rstn_i           (rstn_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_num_bits_i   (cfg_num_bits_i),
    .cfg_num_words_i  (cfg_num_words_i),
    .cfg_data_delay_i (cfg_data_delay_i),
    .cfg_lsb_first_i  (cfg_lsb_first_i),
`ifdef I2S_DSP_RX_SIGN_EXT_EN
    .cfg_sign_ext_i   (cfg_sign_ext_i),
`endif
    .ws_i             (ws_i),
    .sd_i             (sd_i),
    .data_o           (data_o),
    .data_valid_o     (data_valid_o),
    .data_ready_i     (data_ready_i),
    .word_idx_o       (word_idx_o),
    .ovf_o            (ovf_o),
    .frame_err_o      (frame_err_o)
  );

  always #5 sck_i = ~sck_i;

  // Handshake observed mid-cycle: valid & ready here means transfer on the next posedge
  always @(negedge sck_i) begin
    if (rstn_i && data_valid_o) vcnt++;
    if (rstn_i && data_valid_o && data_ready_i) begin
      mon_data.push_back(data_o);
      mon_idx.push_back(word_idx_o);
    end
  end

  task automatic drive(input logic ws, input logic sd);
    @(posedge sck_i);
    #2;
    ws_i = ws;
    sd_i = sd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic push_word(input logic [31:0] w, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      st_ws.push_back(1'b0);
      st_sd.push_back(w[i]);
    end
  endtask

  task automatic play();
    for (int i = 0; i < st_ws.size(); i++) drive(st_ws[i], st_sd[i]);
    st_ws.delete();
    st_sd.delete();
  endtask

  task automatic rx_off_on();
    drive(1'b0, 1'b0);
    cfg_en_i = 1'b0;
    idle(2);
    cfg_en_i = 1'b1;
    idle(2);
  endtask

  task automatic set_cfg(input logic [4:0] nb, input logic [3:0] nw, input logic dly, input logic lsb);
    cfg_num_bits_i   = nb;
    cfg_num_words_i  = nw;
    cfg_data_delay_i = dly;
    cfg_lsb_first_i  = lsb;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge sck_i);
    #2;
    n_cmp++; if (data_o !== 32'h0)     begin n_err++; $display("FAIL rst_data got=%h exp=0", data_o); end
    n_cmp++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", data_valid_o); end
    n_cmp++; if (word_idx_o !== 4'h0)   begin n_err++; $display("FAIL rst_idx got=%h exp=0", word_idx_o); end
    n_cmp++; if (ovf_o !== 1'b0)        begin n_err++; $display("FAIL rst_ovf got=%b exp=0", ovf_o); end
    n_cmp++; if (frame_err_o !== 1'b0)  begin n_err++; $display("FAIL rst_ferr got=%b exp=0", frame_err_o); end
    rstn_i = 1'b1;
  endtask

  task automatic test_basic();
    int b, v0;
    data_ready_i = 1'b1;
    set_cfg(5'd7, 4'd1, 1'b0, 1'b0);
    rx_off_on();
    b = mon_data.size();
    v0 = vcnt;
    push_word(32'hA5, 8);
    push_word(32'h3C, 8);
    st_ws[0] = 1'b1;
    play();
    idle(4);
    n_cmp++; if (mon_data.size() - b !== 2) begin n_err++; $display("FAIL basic_count got=%0d exp=2", mon_data.size() - b); end
    n_cmp++; if (mon_data[b] !== 32'h000000A5) begin n_err++; $display("FAIL basic_w0 got=%h exp=000000a5", mon_data[b]); end
    n_cmp++; if (mon_idx[b] !== 4'd0) begin n_err++; $display("FAIL basic_idx0 got=%0d exp=0", mon_idx[b]); end
    n_cmp++; if (mon_data[b+1] !== 32'h0000003C) begin n_err++; $display("FAIL basic_w1 got=%h exp=0000003c", mon_data[b+1]); end
    n_cmp++; if (mon_idx[b+1] !== 4'd1) begin n_err++; $display("FAIL basic_idx1 got=%0d exp=1", mon_idx[b+1]); end
    n_cmp++; if (vcnt - v0 !== 2) begin n_err++; $display("FAIL basic_valid_cycles got=%0d exp=2", vcnt - v0); end
    n_cmp++; if ({ovf_o, frame_err_o} !== 2'b00) begin n_err++; $display("FAIL basic_flags got=%b exp=00", {ovf_o, frame_err_o}); end
  endtask

  task automatic test_continuous();
    int b;
    logic [7:0] bytes [6];
    bytes = '{8'hA5, 8'h3C, 8'h12, 8'h80, 8'h0F, 8'h37};
    data_ready_i = 1'b1;
    set_cfg(5'd7, 4'd1, 1'b1, 1'b1);
    rx_off_on();
    b = mon_data.size();
    st_ws.push_back(1'b1);
    st_sd.push_back(1'b0);
    for (int i = 0; i < 6; i++) push_word({24'h0, bytes[i]}, 8);
    st_ws[16] = 1'b1;
    st_ws[32] = 1'b1;
    play();
    idle(4);
    n_cmp++; if (mon_data.size() - b !== 6) begin n_err++; $display("FAIL cont_count got=%0d exp=6", mon_data.size() - b); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (mon_data[b+i] !== {24'h0, rev8(bytes[i])} || mon_idx[b+i] !== 4'(i % 2)) begin
        n_err++;
        $display("FAIL cont_word%0d got=%h/idx%0d exp=%h/idx%0d", i, mon_data[b+i], mon_idx[b+i], {24'h0, rev8(bytes[i])}, i % 2);
      end
    end
    n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL cont_ferr got=%b exp=0", frame_err_o); end
  endtask

  task automatic test_overflow();
    int b;
    data_ready_i = 1'b1;
    set_cfg(5'd31, 4'd0, 1'b0, 1'b0);
    rx_off_on();
    data_ready_i = 1'b0;
    b = mon_data.size();
    push_word(32'hDEADBEEF, 32);
    st_ws[0] = 1'b1;
    play();
    idle(2);
    n_cmp++; if (data_valid_o !== 1'b1 || data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL ovf_first got=%b/%h exp=1/deadbeef", data_valid_o, data_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_early got=%b exp=0", ovf_o); end
    push_word(32'h12345678, 32);
    st_ws[0] = 1'b1;
    play();
    idle(2);
    n_cmp++; if (data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL ovf_hold got=%h exp=deadbeef", data_o); end
    n_cmp++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", ovf_o); end
    n_cmp++; if (mon_data.size() - b !== 0) begin n_err++; $display("FAIL ovf_noxfer got=%0d exp=0", mon_data.size() - b); end
    data_ready_i = 1'b1;
    idle(2);
    n_cmp++; if (mon_data.size() - b !== 1) begin n_err++; $display("FAIL ovf_count got=%0d exp=1", mon_data.size() - b); end
    n_cmp++; if (mon_data[b] !== 32'hDEADBEEF) begin n_err++; $display("FAIL ovf_deliver got=%h exp=deadbeef", mon_data[b]); end
    n_cmp++; if (data_valid_o !== 1'b0 || ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_after got=%b/%b exp=0/1", data_valid_o, ovf_o); end
  endtask

  task automatic test_frame_err();
    int b;
    data_ready_i = 1'b1;
    set_cfg(5'd7, 4'd0, 1'b0, 1'b0);
    rx_off_on();
    n_cmp++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL dis_ovf_clr got=%b exp=0", ovf_o); end
    b = mon_data.size();
    push_word(32'h1F, 5);
    push_word(32'h5A, 8);
    st_ws[0] = 1'b1;
    st_ws[5] = 1'b1;
    play();
    idle(4);
    n_cmp++; if (mon_data.size() - b !== 1) begin n_err++; $display("FAIL ferr_count got=%0d exp=1", mon_data.size() - b); end
    n_cmp++; if (mon_data[b] !== 32'h5A || mon_idx[b] !== 4'd0) begin n_err++; $display("FAIL ferr_word got=%h/idx%0d exp=5a/idx0", mon_data[b], mon_idx[b]); end
    n_cmp++; if (frame_err_o !== 1'b1) begin n_err++; $display("FAIL ferr_flag got=%b exp=1", frame_err_o); end
    cfg_en_i = 1'b0;
    idle(2);
    n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL dis_ferr_clr got=%b exp=0", frame_err_o); end
    cfg_en_i = 1'b1;
    idle(2);
  endtask

  task automatic test_single_bit();
    int b, v0;
    logic [15:0] pat;
    pat = 16'h9D1B;
    data_ready_i = 1'b1;
    set_cfg(5'd0, 4'd15, 1'b0, 1'b0);
    rx_off_on();
    b = mon_data.size();
    v0 = vcnt;
    push_word({16'h0, pat}, 16);
    st_ws[0] = 1'b1;
    play();
    idle(4);
    n_cmp++; if (mon_data.size() - b !== 16) begin n_err++; $display("FAIL bit1_count got=%0d exp=16", mon_data.size() - b); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mon_data[b+i] !== {31'h0, pat[15-i]} || mon_idx[b+i] !== 4'(i)) begin
        n_err++;
        $display("FAIL bit1_word%0d got=%h/idx%0d exp=%h/idx%0d", i, mon_data[b+i], mon_idx[b+i], {31'h0, pat[15-i]}, i);
      end
    end
    n_cmp++; if (vcnt - v0 !== 16) begin n_err++; $display("FAIL bit1_valid_cycles got=%0d exp=16", vcnt - v0); end
  endtask

  task automatic test_sign_ext();
    int b;
    data_ready_i = 1'b1;
    set_cfg(5'd11, 4'd0, 1'b0, 1'b0);
    rx_off_on();
`ifdef I2S_DSP_RX_SIGN_EXT_EN
    cfg_sign_ext_i = 1'b1;
    b = mon_data.size();
    push_word(32'h800, 12);
    st_ws[0] = 1'b1;
    play();
    idle(3);
    n_cmp++; if (mon_data[b] !== 32'hFFFFF800) begin n_err++; $display("FAIL sext_on got=%h exp=fffff800", mon_data[b]); end
    cfg_sign_ext_i = 1'b0;
`endif
    b = mon_data.size();
    push_word(32'h800, 12);
    st_ws[0] = 1'b1;
    play();
    idle(3);
    n_cmp++; if (mon_data[b] !== 32'h00000800) begin n_err++; $display("FAIL sext_off got=%h exp=00000800", mon_data[b]); end
  endtask

  task automatic test_reset_midframe();
    int b;
    data_ready_i = 1'b1;
    set_cfg(5'd7, 4'd1, 1'b0, 1'b0);
    rx_off_on();
    data_ready_i = 1'b0;
    push_word(32'hC3, 8);
    push_word(32'h5, 3);
    st_ws[0] = 1'b1;
    play();
    drive(1'b0, 1'b0);
    n_cmp++; if (data_valid_o !== 1'b1 || data_o !== 32'hC3) begin n_err++; $display("FAIL mrst_pre got=%b/%h exp=1/c3", data_valid_o, data_o); end
    rstn_i = 1'b0;
    #1;
    n_cmp++; if (data_valid_o !== 1'b0 || data_o !== 32'h0) begin n_err++; $display("FAIL mrst_out got=%b/%h exp=0/0", data_valid_o, data_o); end
    idle(1);
    rstn_i = 1'b1;
    data_ready_i = 1'b1;
    idle(2);
    b = mon_data.size();
    push_word(32'h81, 8);
    push_word(32'h42, 8);
    st_ws[0] = 1'b1;
    play();
    idle(4);
    n_cmp++; if (mon_data.size() - b !== 2) begin n_err++; $display("FAIL mrst_count got=%0d exp=2", mon_data.size() - b); end
    n_cmp++; if (mon_data[b] !== 32'h81 || mon_idx[b] !== 4'd0) begin n_err++; $display("FAIL mrst_w0 got=%h/idx%0d exp=81/idx0", mon_data[b], mon_idx[b]); end
    n_cmp++; if (mon_data[b+1] !== 32'h42 || mon_idx[b+1] !== 4'd1) begin n_err++; $display("FAIL mrst_w1 got=%h/idx%0d exp=42/idx1", mon_data[b+1], mon_idx[b+1]); end
  endtask

  initial begin
    rstn_i       = 1'b0;
    cfg_en_i     = 1'b0;
    data_ready_i = 1'b0;
    ws_i         = 1'b0;
    sd_i         = 1'b0;
`ifdef I2S_DSP_RX_SIGN_EXT_EN
    cfg_sign_ext_i = 1'b0;
`endif
    set_cfg(5'd0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_continuous();
    test_overflow();
    test_frame_err();
    test_single_bit();
    test_sign_ext();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
